// File: rtl/sfu_max_sub.sv
`default_nettype none
// ============================================================================
// Module   : sfu_max_sub
// Purpose  : Softmax pre-stage. Reads a row of scores from scache, subtracts
//            the row maximum with saturation, writes it back, then runs the SFU.
// Revision : 1.0 - initial release
// ============================================================================
module sfu_max_sub #(
    parameter int LANES = 8,
    parameter int DW    = 16,
    parameter int AW    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       row_addr,
    input  logic [7:0]          row_cnt,
    input  logic [3:0]          cfg_valid_lanes,
    output logic                busy,
    output logic                done,
    output logic                cub_sfu_req,
    output logic                cub_sfu_we,
    output logic [AW-1:0]       cub_sfu_addr,
    input  logic                cub_sfu_gnt,
    output logic [LANES*32-1:0] cub_sfu_wdata,
    output logic [LANES*4-1:0]  cub_sfu_be,
    input  logic [LANES*32-1:0] cub_sfu_rdata,
    input  logic [LANES-1:0]    cub_sfu_rvalid,
    output logic                sfu_start,
    output logic [AW-1:0]       sfu_rw_scache_addr,
    input  logic                sfu_done
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = 4;
    localparam logic signed [DW-1:0] C_MIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] C_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [CW-1:0]        C_LANES = CW'(LANES);
    localparam logic [IW-1:0]        C_LAST  = IW'(LANES - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RD_REQ   = 4'd1,
        ST_RD_WAIT  = 4'd2,
        ST_MAX      = 4'd3,
        ST_SUB      = 4'd4,
        ST_WR_REQ   = 4'd5,
        ST_SFU_GO   = 4'd6,
        ST_SFU_WAIT = 4'd7,
        ST_NEXT     = 4'd8
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [AW-1:0]           r_addr;
    logic [7:0]              r_remain;
    logic [CW-1:0]           r_nvalid;
    logic [CW-1:0]           w_nvalid;
    logic [LANES-1:0]        r_flags;
    logic [IW-1:0]           r_idx;
    logic signed [DW-1:0]    r_max;
    logic signed [DW-1:0]    w_cur;
    logic                    w_take;
    logic                    w_last;
    logic [31:0]             r_lane [LANES];
    logic [DW-1:0]           w_diff [LANES];

    // Out-of-range lane counts are folded into the legal 1..LANES range.
    always_comb begin
        w_nvalid = cfg_valid_lanes;
        if (cfg_valid_lanes == '0) begin
            w_nvalid = CW'(1);
        end else if (cfg_valid_lanes > C_LANES) begin
            w_nvalid = C_LANES;
        end
    end

    assign w_cur  = r_lane[r_idx][DW-1:0];
    assign w_take = (CW'(r_idx) < r_nvalid) && (w_cur > r_max);
    assign w_last = (r_remain <= 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cub_sfu_req = 1'b0;
        cub_sfu_we  = 1'b0;
        sfu_start   = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (row_cnt == 8'd0) ? ST_NEXT : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                cub_sfu_req = 1'b1;
                if (cub_sfu_gnt) begin
                    w_state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (&(r_flags | cub_sfu_rvalid)) begin
                    w_state_nxt = ST_MAX;
                end
            end
            ST_MAX: begin
                if (r_idx == C_LAST) begin
                    w_state_nxt = ST_SUB;
                end
            end
            ST_SUB: begin
                w_state_nxt = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                cub_sfu_req = 1'b1;
                cub_sfu_we  = 1'b1;
                if (cub_sfu_gnt) begin
                    w_state_nxt = ST_SFU_GO;
                end
            end
            ST_SFU_GO: begin
                sfu_start   = 1'b1;
                w_state_nxt = ST_SFU_WAIT;
            end
            ST_SFU_WAIT: begin
                if (sfu_done) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (w_last) begin
                    done        = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RD_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // busy falls in the same cycle done is raised.
    assign busy               = (r_state != ST_IDLE) && !done;
    assign cub_sfu_addr       = r_addr;
    assign sfu_rw_scache_addr = r_addr;
    assign cub_sfu_be         = {(LANES*4){1'b1}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_nvalid <= '0;
            r_flags  <= '0;
            r_idx    <= '0;
            r_max    <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_lane[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr   <= row_addr;
                        r_remain <= row_cnt;
                        r_nvalid <= w_nvalid;
                    end
                end
                ST_RD_REQ: begin
                    r_flags <= '0;
                    r_idx   <= '0;
                    r_max   <= C_MIN;
                end
                ST_RD_WAIT: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (cub_sfu_rvalid[i]) begin
                            r_lane[i]  <= cub_sfu_rdata[32*i +: 32];
                            r_flags[i] <= 1'b1;
                        end
                    end
                end
                ST_MAX: begin
                    if (w_take) begin
                        r_max <= w_cur;
                    end
                    r_idx <= r_idx + 1'b1;
                end
                ST_SUB: begin
                    for (int i = 0; i < LANES; i++) begin
                        r_lane[i] <= {{(32-DW){1'b0}}, w_diff[i]};
                    end
                end
                ST_NEXT: begin
                    r_addr <= r_addr + AW'(1);
                    if (r_remain != 8'd0) begin
                        r_remain <= r_remain - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Per-lane subtract at DW+1 bits; the sign/overflow pair selects saturation.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [CW-1:0] C_IDX = CW'(gi);
        logic signed [DW:0] w_ext;
        logic [DW-1:0]      w_res;

        assign w_ext = $signed({r_lane[gi][DW-1], r_lane[gi][DW-1:0]})
                     - $signed({r_max[DW-1], r_max});

        always_comb begin
            w_res = w_ext[DW-1:0];
            if (C_IDX >= r_nvalid) begin
                w_res = C_MIN;
            end else if (w_ext[DW] != w_ext[DW-1]) begin
                w_res = w_ext[DW] ? C_MIN : C_MAX;
            end
        end

        assign w_diff[gi]                  = w_res;
        assign cub_sfu_wdata[32*gi +: 32]  = r_lane[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_sfu_max_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfu_max_sub
// Purpose  : Scoreboard bench for sfu_max_sub with scache and SFU responders.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfu_max_sub;

    localparam int LANES = 8;
    localparam int DW    = 16;
    localparam int AW    = 7;

    typedef struct packed {
        logic [AW-1:0]       addr;
        logic [LANES*32-1:0] data;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [AW-1:0]       row_addr;
    logic [7:0]          row_cnt;
    logic [3:0]          cfg_valid_lanes;
    logic                busy;
    logic                done;
    logic                req;
    logic                we;
    logic [AW-1:0]       addr;
    logic                gnt;
    logic [LANES*32-1:0] wdata;
    logic [LANES*4-1:0]  be;
    logic [LANES*32-1:0] rdata;
    logic [LANES-1:0]    rvalid;
    logic                sfu_start;
    logic [AW-1:0]       sfu_addr;
    logic                sfu_done;

    sfu_max_sub #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .row_addr           (row_addr),
        .row_cnt            (row_cnt),
        .cfg_valid_lanes    (cfg_valid_lanes),
        .busy               (busy),
        .done               (done),
        .cub_sfu_req        (req),
        .cub_sfu_we         (we),
        .cub_sfu_addr       (addr),
        .cub_sfu_gnt        (gnt),
        .cub_sfu_wdata      (wdata),
        .cub_sfu_be         (be),
        .cub_sfu_rdata      (rdata),
        .cub_sfu_rvalid     (rvalid),
        .sfu_start          (sfu_start),
        .sfu_rw_scache_addr (sfu_addr),
        .sfu_done           (sfu_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [LANES*32-1:0] mem [128];
    logic [AW-1:0]       exp_rd_q [$];
    wr_t                 exp_wr_q [$];
    logic [AW-1:0]       exp_sfu_q [$];

    int gnt_delay = 0;
    int rv_mode   = 0;
    bit spur_en   = 1'b0;
    int sfu_lat   = 3;

    int            wait_cnt, rd_phase, sfu_cnt;
    int            n_done = 0, n_sfu = 0, n_req = 0, last_sfu_cyc = 0;
    bit            exp_we;
    logic [AW-1:0] rd_addr, ra_exp, sfu_exp;
    wr_t           w_exp;

    task automatic check(input string tag, input logic [LANES*32-1:0] act,
                         input logic [LANES*32-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*32-1:0] model_row(input logic [LANES*32-1:0] row,
                                                      input int nv_raw);
        int nv, mx, v, d, lo;
        logic signed [DW-1:0] s;
        logic [LANES*32-1:0]  res;
        nv  = (nv_raw < 1) ? 1 : ((nv_raw > LANES) ? LANES : nv_raw);
        lo  = -(1 << (DW - 1));
        mx  = lo;
        res = '0;
        for (int i = 0; i < nv; i++) begin
            s = row[32*i +: DW];
            v = s;
            if (v > mx) mx = v;
        end
        for (int i = 0; i < LANES; i++) begin
            s = row[32*i +: DW];
            v = s;
            d = (i >= nv) ? lo : (v - mx);
            if (d < lo) d = lo;
            res[32*i +: DW] = d[DW-1:0];
        end
        return res;
    endfunction

    function automatic logic [LANES-1:0] lanes_for(input int mode, input int ph);
        if (mode == 0) return (ph == 0) ? {LANES{1'b1}} : {LANES{1'b0}};
        case (ph)
            0:       return 8'b0000_0111;
            2:       return 8'b0011_1000;
            3:       return 8'b1100_0000;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic push_job(input int a, input int cnt, input int nv);
        logic [AW-1:0] ra;
        wr_t           w;
        for (int r = 0; r < cnt; r++) begin
            ra     = AW'(a + r);
            w.addr = ra;
            w.data = model_row(mem[ra], nv);
            exp_rd_q.push_back(ra);
            exp_wr_q.push_back(w);
            exp_sfu_q.push_back(ra);
        end
    endtask

    // scache + SFU responder: grants, read data, write scoring, SFU completion
    initial begin
        gnt = 1'b0; rvalid = '0; rdata = '0; sfu_done = 1'b0;
        rd_phase = -1; wait_cnt = 0; sfu_cnt = 0; exp_we = 1'b0;
        forever begin
            step();
            gnt = 1'b0; rvalid = '0; sfu_done = 1'b0;
            if (rst) begin
                rd_phase = -1; wait_cnt = 0; sfu_cnt = 0; exp_we = 1'b0;
            end else begin
                if (done) n_done++;
                if (rd_phase >= 0) begin
                    rvalid = lanes_for(rv_mode, rd_phase);
                    for (int l = 0; l < LANES; l++)
                        rdata[32*l +: 32] = rvalid[l] ? mem[rd_addr][32*l +: 32] : $urandom;
                    if (spur_en && rd_phase == 6) sfu_done = 1'b1;
                    rd_phase = (rd_phase == 8) ? -1 : rd_phase + 1;
                end
                if (sfu_cnt > 0) begin
                    check("sfu_addr_hold", sfu_addr, sfu_exp);
                    sfu_cnt--;
                    if (sfu_cnt == 0) sfu_done = 1'b1;
                end
                if (sfu_start) begin
                    n_sfu++;
                    last_sfu_cyc = cyc;
                    if (exp_sfu_q.size() == 0) check("sfu_unexpected", 1, 0);
                    else begin
                        sfu_exp = exp_sfu_q.pop_front();
                        check("sfu_addr", sfu_addr, sfu_exp);
                    end
                    sfu_cnt = sfu_lat;
                end
                if (req) begin
                    n_req++;
                    check("req_we", we, exp_we);
                    if (wait_cnt < gnt_delay) begin
                        wait_cnt++;
                        if (!exp_we && exp_rd_q.size() > 0)
                            check("rd_hold_addr", addr, exp_rd_q[0]);
                        if (exp_we && exp_wr_q.size() > 0) begin
                            check("wr_hold_addr", addr, exp_wr_q[0].addr);
                            check("wr_hold_data", wdata, exp_wr_q[0].data);
                        end
                    end else begin
                        gnt = 1'b1;
                        wait_cnt = 0;
                        if (!exp_we) begin
                            if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
                            else begin
                                ra_exp = exp_rd_q.pop_front();
                                check("rd_addr", addr, ra_exp);
                            end
                            rd_addr  = addr;
                            rd_phase = 0;
                            exp_we   = 1'b1;
                        end else begin
                            if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
                            else begin
                                w_exp = exp_wr_q.pop_front();
                                check("wr_addr", addr, w_exp.addr);
                                check("wr_data", wdata, w_exp.data);
                            end
                            exp_we = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic run_job(input int a, input int cnt, input int nv, input bit extra,
                           output int lat);
        int d0, s0, r0, sc, got;
        push_job(a, cnt, nv);
        d0 = n_done; s0 = n_sfu; r0 = n_req;
        row_addr = AW'(a); row_cnt = 8'(cnt); cfg_valid_lanes = 4'(nv);
        start = 1'b1;
        sc  = cyc;
        got = -1;
        for (int i = 0; i < 3000; i++) begin
            step();
            start = extra && (i == 3);
            if (start) begin
                row_addr = 7'd99;
                row_cnt  = 8'd1;
            end
            if (i == 0) check("busy_after_start", busy, cnt != 0);
            if (done) begin
                got = i;
                break;
            end
        end
        start = 1'b0;
        if (got < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            check("busy_at_done", busy, 0);
            if (cnt == 0) begin
                check("zero_done_latency", got, 0);
                check("zero_no_req", n_req - r0, 0);
            end
            start = 1'b1;
            row_cnt = 8'd1;
            step();
            start = 1'b0;
            check("start_on_done_ignored", busy, 0);
            check("sfu_pulses", n_sfu - s0, cnt);
            check("done_pulses", n_done - d0, 1);
            check("queues_drained", exp_rd_q.size() + exp_wr_q.size() + exp_sfu_q.size(), 0);
        end
        lat = last_sfu_cyc - sc;
    endtask

    initial begin
        int lat, d0, s0;
        int row2 [LANES] = '{10, -3, 200, 0, 7, 200, -32768, 1};
        int row3 [LANES] = '{32767, -32768, 0, 32767, 32767, 32767, 32767, 32767};
        rst = 1'b1; start = 1'b0; row_addr = '0; row_cnt = '0; cfg_valid_lanes = '0;
        for (int r = 0; r < 128; r++)
            for (int l = 0; l < LANES; l++)
                mem[r][32*l +: 32] = $urandom;
        for (int l = 0; l < LANES; l++) begin
            mem[5][32*l +: 32]  = 32'(row2[l]);
            mem[20][32*l +: 32] = 32'(row3[l]);
            mem[62][32*l +: 32] = 32'h0000_04d2;
        end
        repeat (3) step();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", req, 0);
        check("rst_we", we, 0);
        check("rst_sfu_start", sfu_start, 0);
        check("rst_wdata", wdata, 0);
        check("rst_addr", addr, 0);
        check("rst_sfu_addr", sfu_addr, 0);
        check("be_all_ones", be, {(LANES*4){1'b1}});
        rst = 1'b0;
        step();

        // reset while the max search is running
        d0 = n_done; s0 = n_sfu;
        push_job(10, 1, 8);
        row_addr = 7'd10; row_cnt = 8'd1; cfg_valid_lanes = 4'd8; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_busy", busy, 0);
        check("midrst_req", req, 0);
        check("midrst_sfu_start", sfu_start, 0);
        check("midrst_done", done, 0);
        check("midrst_wdata", wdata, 0);
        check("midrst_addr", addr, 0);
        step();
        rst = 1'b0;
        exp_rd_q.delete(); exp_wr_q.delete(); exp_sfu_q.delete();
        repeat (20) step();
        check("midrst_no_done", n_done - d0, 0);
        check("midrst_no_sfu", n_sfu - s0, 0);

        run_job(5, 1, 8, 1'b0, lat);
        check("row_latency", lat, 13);
        run_job(20, 1, 3, 1'b0, lat);
        run_job(126, 3, 8, 1'b0, lat);
        run_job(60, 1, 0, 1'b0, lat);
        run_job(61, 1, 15, 1'b0, lat);
        run_job(62, 1, 8, 1'b0, lat);

        gnt_delay = 4; rv_mode = 1; spur_en = 1'b1; sfu_lat = 5;
        run_job(40, 2, 5, 1'b1, lat);
        gnt_delay = 0; rv_mode = 0; spur_en = 1'b0; sfu_lat = 3;

        run_job(30, 0, 8, 1'b0, lat);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
